// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control sequencer: one datapath phase per cycle, ready
// handshake on data memory, sticky fault on illegal encodings or timeouts.
module multicycle_ctrl #(
  parameter int unsigned ALU_CC_W = 4,
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [6:0]          opcode,
  input  logic [6:0]          funct7,
  input  logic [2:0]          funct3,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem2reg,
  output logic                alu_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ALU_CC_W-1:0] alu_cc,
  output logic                busy,
  output logic                fault,
  output logic [1:0]          fault_code,
  output logic [CNT_W-1:0]    retired
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [ALU_CC_W-1:0] CC_AND  = ALU_CC_W'(0);
  localparam logic [ALU_CC_W-1:0] CC_OR   = ALU_CC_W'(1);
  localparam logic [ALU_CC_W-1:0] CC_ADD  = ALU_CC_W'(2);
  localparam logic [ALU_CC_W-1:0] CC_XOR  = ALU_CC_W'(3);
  localparam logic [ALU_CC_W-1:0] CC_SLL  = ALU_CC_W'(4);
  localparam logic [ALU_CC_W-1:0] CC_SRL  = ALU_CC_W'(5);
  localparam logic [ALU_CC_W-1:0] CC_SUB  = ALU_CC_W'(6);
  localparam logic [ALU_CC_W-1:0] CC_SLT  = ALU_CC_W'(7);
  localparam logic [ALU_CC_W-1:0] CC_SRA  = ALU_CC_W'(8);
  localparam logic [ALU_CC_W-1:0] CC_SLTU = ALU_CC_W'(9);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
  } state_e;

  typedef enum logic [1:0] {C_R, C_I, C_LW, C_SW} cls_e;

  state_e              state_q, state_d;
  logic [6:0]          op_q, op_d, f7_q, f7_d;
  logic [2:0]          f3_q, f3_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                fault_q, fault_d;
  logic [1:0]          fault_code_q, fault_code_d;

  logic                pc_write_q, pc_write_d, ir_write_q, ir_write_d;
  logic                reg_write_q, reg_write_d, mem2reg_q, mem2reg_d;
  logic                alu_src_q, alu_src_d, mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d, busy_q, busy_d;
  logic [ALU_CC_W-1:0] alu_cc_q, alu_cc_d;

  logic                legal_c;
  logic                alt_c;
  cls_e                cls_c;
  logic [ALU_CC_W-1:0] cc_c;

  // Instruction fields are captured on the DECODE exit edge and held afterwards.
  always_comb begin
    op_d = op_q;
    f3_d = f3_q;
    f7_d = f7_q;
    if (state_q == S_DECODE) begin
      op_d = opcode;
      f3_d = funct3;
      f7_d = funct7;
    end
  end

  assign alt_c = (f7_d == F7_ALT);

  // Decode of the (live-in-DECODE, held-otherwise) fields: legality, class, ALU code.
  always_comb begin
    legal_c = 1'b0;
    cls_c   = C_R;
    cc_c    = CC_ADD;
    case (f3_d)
      3'b000:  cc_c = (alt_c && (op_d == OP_R)) ? CC_SUB : CC_ADD;
      3'b001:  cc_c = CC_SLL;
      3'b010:  cc_c = CC_SLT;
      3'b011:  cc_c = CC_SLTU;
      3'b100:  cc_c = CC_XOR;
      3'b101:  cc_c = alt_c ? CC_SRA : CC_SRL;
      3'b110:  cc_c = CC_OR;
      default: cc_c = CC_AND;
    endcase
    case (op_d)
      OP_R: begin
        cls_c   = C_R;
        legal_c = (f7_d == F7_BASE) || (alt_c && ((f3_d == 3'b000) || (f3_d == 3'b101)));
      end
      OP_I: begin
        cls_c = C_I;
        if (f3_d == 3'b001)      legal_c = (f7_d == F7_BASE);
        else if (f3_d == 3'b101) legal_c = (f7_d == F7_BASE) || alt_c;
        else                     legal_c = 1'b1;
      end
      OP_LW: begin
        cls_c   = C_LW;
        cc_c    = CC_ADD;
        legal_c = (f3_d == 3'b010);
      end
      OP_SW: begin
        cls_c   = C_SW;
        cc_c    = CC_ADD;
        legal_c = (f3_d == 3'b010);
      end
      default: legal_c = 1'b0;
    endcase
  end

  // Next-state, wait counter, retire counter and sticky fault.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    retired_d    = retired_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (legal_c) begin
          state_d = S_EXEC;
        end else begin
          state_d      = S_FAULT;
          fault_d      = 1'b1;
          fault_code_d = 2'b01;
        end
      end
      S_EXEC:   state_d = ((cls_c == C_LW) || (cls_c == C_SW)) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ready) begin
          wait_d = '0;
          if (cls_c == C_LW) begin
            state_d = S_WB;
          end else begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = run ? S_FETCH : S_IDLE;
          end
        end else if (wait_q == WAIT_LAST) begin
          wait_d       = '0;
          state_d      = S_FAULT;
          fault_d      = 1'b1;
          fault_code_d = 2'b10;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = run ? S_FETCH : S_IDLE;
      end
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control outputs decoded from the next state so the registered copies track the state.
  always_comb begin
    pc_write_d  = (state_d == S_FETCH);
    ir_write_d  = (state_d == S_FETCH);
    reg_write_d = (state_d == S_WB);
    mem2reg_d   = (state_d == S_WB) && (cls_c == C_LW);
    mem_read_d  = (state_d == S_MEM) && (cls_c == C_LW);
    mem_write_d = (state_d == S_MEM) && (cls_c == C_SW);
    busy_d      = (state_d != S_IDLE) && (state_d != S_FAULT);
    alu_src_d   = 1'b0;
    alu_cc_d    = '0;
    if ((state_d == S_EXEC) || (state_d == S_MEM) || (state_d == S_WB)) begin
      alu_src_d = (cls_c != C_R);
      alu_cc_d  = cc_c;
    end
  end

  // State, datapath-field and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      f3_q         <= '0;
      f7_q         <= '0;
      wait_q       <= '0;
      retired_q    <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
      pc_write_q   <= 1'b0;
      ir_write_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      mem2reg_q    <= 1'b0;
      alu_src_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      busy_q       <= 1'b0;
      alu_cc_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      f3_q         <= f3_d;
      f7_q         <= f7_d;
      wait_q       <= wait_d;
      retired_q    <= retired_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      pc_write_q   <= pc_write_d;
      ir_write_q   <= ir_write_d;
      reg_write_q  <= reg_write_d;
      mem2reg_q    <= mem2reg_d;
      alu_src_q    <= alu_src_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      busy_q       <= busy_d;
      alu_cc_q     <= alu_cc_d;
    end
  end

  assign pc_write   = pc_write_q;
  assign ir_write   = ir_write_q;
  assign reg_write  = reg_write_q;
  assign mem2reg    = mem2reg_q;
  assign alu_src    = alu_src_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign alu_cc     = alu_cc_q;
  assign busy       = busy_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle output trace; one process compares.
module tb_multicycle_ctrl;

  localparam int unsigned TIMEOUT = 15;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  logic       clk = 1'b0;
  logic       reset, run, mem_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       pc_write, ir_write, reg_write, mem2reg, alu_src, mem_read, mem_write;
  logic [3:0] alu_cc;
  logic       busy, fault;
  logic [1:0] fault_code;
  logic [3:0] retired;

  multicycle_ctrl #(.ALU_CC_W(4), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct7(funct7),
    .funct3(funct3), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem2reg(mem2reg), .alu_src(alu_src), .mem_read(mem_read),
    .mem_write(mem_write), .alu_cc(alu_cc), .busy(busy), .fault(fault),
    .fault_code(fault_code), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_write, ir_write, reg_write, mem2reg, alu_src, mem_read, mem_write;
    logic [3:0] alu_cc;
    logic busy, fault;
    logic [1:0] fault_code;
    logic [3:0] retired;
  } outv_t;

  typedef struct packed {
    logic run;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic mem_ready;
  } inv_t;

  typedef struct { inv_t i; outv_t o; } cyc_t;

  cyc_t  sched[$];
  outv_t exp_cur, act;
  logic  chk_en;
  int    n_vec = 0, n_err = 0;
  int    cnt_mr = 0, cnt_mw = 0, cnt_busy = 0;

  // Architectural model state.
  logic [3:0] m_ret;
  logic       m_fault;
  logic [1:0] m_code;

  // ALU codes of funct3 000..111 without the alternate funct7 (ADD SLL SLT SLTU XOR SRL OR AND).
  logic [3:0] cc_tbl [0:7] = '{4'd2, 4'd4, 4'd7, 4'd9, 4'd3, 4'd5, 4'd1, 4'd0};

  // Per-cycle comparison of every output against the model trace.
  always @(negedge clk) begin
    if (chk_en) begin
      act = {pc_write, ir_write, reg_write, mem2reg, alu_src, mem_read, mem_write,
             alu_cc, busy, fault, fault_code, retired};
      n_vec++;
      if (act !== exp_cur) begin
        n_err++;
        $display("FAIL outputs @%0t actual=%b required=%b (pcw irw rw m2r asrc mr mw cc4 busy flt code2 ret4)",
                 $time, act, exp_cur);
      end
      cnt_mr   += int'(mem_read);
      cnt_mw   += int'(mem_write);
      cnt_busy += int'(busy);
    end
  end

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, a, e, $time);
    end
  endtask

  // Reference instruction classification: returns legality, kind 0 R / 1 I / 2 LW / 3 SW.
  function automatic bit ref_dec(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, output int kind, output logic [3:0] cc);
    kind = -1;
    cc   = 4'd2;
    if (op == OP_R) begin
      kind = 0;
      if (f7 == 7'h00) begin cc = cc_tbl[f3]; return 1'b1; end
      if (f7 == 7'h20 && f3 == 3'd0) begin cc = 4'd6; return 1'b1; end
      if (f7 == 7'h20 && f3 == 3'd5) begin cc = 4'd8; return 1'b1; end
      return 1'b0;
    end
    if (op == OP_I) begin
      kind = 1;
      if (f3 == 3'd1 && f7 != 7'h00) return 1'b0;
      if (f3 == 3'd5) begin
        if (f7 == 7'h00) cc = 4'd5;
        else if (f7 == 7'h20) cc = 4'd8;
        else return 1'b0;
        return 1'b1;
      end
      cc = cc_tbl[f3];
      return 1'b1;
    end
    if (op == OP_LW) begin kind = 2; return f3 == 3'd2; end
    if (op == OP_SW) begin kind = 3; return f3 == 3'd2; end
    return 1'b0;
  endfunction

  function automatic inv_t rand_in();
    inv_t i;
    i = inv_t'(19'($urandom));
    return i;
  endfunction

  function automatic outv_t mk(input logic pcw, irw, rw, m2r, asrc, mr, mw,
                               input logic [3:0] cc, input logic bsy);
    outv_t o;
    o = {pcw, irw, rw, m2r, asrc, mr, mw, cc, bsy, m_fault, m_code, m_ret};
    return o;
  endfunction

  task automatic push(input inv_t i, input outv_t o);
    cyc_t c;
    c.i = i;
    c.o = o;
    sched.push_back(c);
  endtask

  // n_low idle cycles with run=0, then optionally one with run=1 to start.
  task automatic add_idle(input int n_low, input bit go);
    inv_t i;
    for (int k = 0; k < n_low; k++) begin
      i = rand_in(); i.run = 1'b0;
      push(i, mk(0, 0, 0, 0, 0, 0, 0, 4'd0, 0));
    end
    if (go) begin
      i = rand_in(); i.run = 1'b1;
      push(i, mk(0, 0, 0, 0, 0, 0, 0, 4'd0, 0));
    end
  endtask

  task automatic add_fault(input logic [1:0] code);
    m_fault = 1'b1;
    m_code  = code;
    for (int k = 0; k < 3; k++) push(rand_in(), mk(0, 0, 0, 0, 0, 0, 0, 4'd0, 0));
  endtask

  // One instruction from FETCH; waits = mem_ready-low cycles before ready.
  task automatic add_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input int waits, input bit run_next);
    inv_t i;
    int kind, nmem;
    logic [3:0] cc;
    bit legal, asrc;
    legal = ref_dec(op, f3, f7, kind, cc);
    push(rand_in(), mk(1, 1, 0, 0, 0, 0, 0, 4'd0, 1));
    i = rand_in(); i.opcode = op; i.f3 = f3; i.f7 = f7;
    push(i, mk(0, 0, 0, 0, 0, 0, 0, 4'd0, 1));
    if (!legal) begin add_fault(2'b01); return; end
    asrc = (kind != 0);
    push(rand_in(), mk(0, 0, 0, 0, asrc, 0, 0, cc, 1));
    if (kind >= 2) begin
      nmem = (waits >= int'(TIMEOUT)) ? int'(TIMEOUT) : waits + 1;
      for (int k = 0; k < nmem; k++) begin
        i = rand_in();
        i.mem_ready = (k == waits);
        if (k == waits) i.run = run_next;
        push(i, mk(0, 0, 0, 0, 1, kind == 2, kind == 3, cc, 1));
      end
      if (waits >= int'(TIMEOUT)) begin add_fault(2'b10); return; end
      if (kind == 3) begin m_ret = m_ret + 4'd1; return; end
    end
    i = rand_in(); i.run = run_next;
    push(i, mk(0, 0, 1, kind == 2, asrc, 0, 0, cc, 1));
    m_ret = m_ret + 4'd1;
  endtask

  task automatic apply(input cyc_t c);
    run = c.i.run; opcode = c.i.opcode; funct3 = c.i.f3; funct7 = c.i.f7;
    mem_ready = c.i.mem_ready;
    exp_cur = c.o;
  endtask

  task automatic play_n(input int n);
    for (int k = 0; k < n && sched.size() > 0; k++) begin
      apply(sched.pop_front());
      @(posedge clk); #1;
    end
  endtask

  task automatic play();
    play_n(sched.size());
  endtask

  // Asynchronous reset mid-cycle, held two cycles with issue requested.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    exp_cur = '0;
    sched.delete();
    m_ret = 4'd0; m_fault = 1'b0; m_code = 2'b00;
    for (int k = 0; k < 2; k++) begin
      apply('{i: rand_in(), o: '0});
      run = 1'b1;
      @(posedge clk); #1;
    end
    reset = 1'b1;
  endtask

  initial begin
    int sel, waits;
    bit rn;
    logic [6:0] op, f7;
    logic [2:0] f3;
    m_ret = 4'd0; m_fault = 1'b0; m_code = 2'b00;
    reset = 1'b0; exp_cur = '0; chk_en = 1'b1;
    apply('{i: rand_in(), o: '0});
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Idle hold with run low.
    add_idle(4, 0); play();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_retired", 32'(retired), 0);

    // ADD: four cycles, check ALU control in EXEC.
    add_idle(0, 1); add_instr(OP_R, 3'd0, 7'h00, 0, 0); add_idle(2, 0);
    play_n(3);
    chk("add_exec_cc", 32'(alu_cc), 32'h2);
    chk("add_exec_src", 32'(alu_src), 0);
    play();
    chk("add_retired", 32'(retired), 1);

    // SUB and SRAI codes held in WB.
    add_idle(0, 1); add_instr(OP_R, 3'd0, 7'h20, 0, 1); add_instr(OP_I, 3'd5, 7'h20, 0, 0);
    add_idle(1, 0);
    play_n(4);
    chk("sub_wb_cc", 32'(alu_cc), 32'h6);
    chk("sub_wb_rw", 32'(reg_write), 1);
    play_n(4);
    chk("srai_wb_cc", 32'(alu_cc), 32'h8);
    chk("srai_wb_src", 32'(alu_src), 1);
    play();

    // LW with three wait cycles: 4 MEM cycles, 8 busy cycles.
    cnt_mr = 0; cnt_busy = 0;
    add_idle(0, 1); add_instr(OP_LW, 3'd2, 7'($urandom), 3, 0); add_idle(2, 0); play();
    chk("lw_mem_cycles", 32'(cnt_mr), 4);
    chk("lw_busy_cycles", 32'(cnt_busy), 8);
    chk("lw_retired", 32'(retired), 4);

    // SW that never completes: 15 MEM cycles then memory-timeout fault.
    cnt_mw = 0;
    add_idle(0, 1); add_instr(OP_SW, 3'd2, 7'($urandom), 1000, 1); play();
    chk("sw_timeout_mw_cycles", 32'(cnt_mw), 15);
    chk("sw_timeout_fault", 32'(fault), 1);
    chk("sw_timeout_code", 32'(fault_code), 2);
    do_reset();

    // Branch opcode after a legal instruction: illegal, retired unchanged.
    add_idle(1, 1); add_instr(OP_R, 3'd0, 7'h00, 0, 1);
    add_instr(7'b1100011, 3'($urandom), 7'($urandom), 0, 1); play();
    chk("illegal_op_code", 32'(fault_code), 1);
    chk("illegal_op_retired", 32'(retired), 1);
    do_reset();
    add_idle(1, 1); add_instr(OP_R, 3'd1, 7'h20, 0, 1); play();
    chk("illegal_funct_code", 32'(fault_code), 1);
    do_reset();

    // 16 back-to-back ADDI wrap the 4-bit counter; run drops during the 17th EXEC.
    add_idle(1, 1);
    for (int k = 0; k < 16; k++) add_instr(OP_I, 3'd0, 7'($urandom), 0, 1);
    play();
    chk("wrap_retired", 32'(retired), 0);
    add_instr(OP_I, 3'd0, 7'($urandom), 0, 0);
    sched[2].i.run = 1'b0;
    add_idle(2, 0); play();
    chk("wrap_last_retired", 32'(retired), 1);
    chk("wrap_idle_busy", 32'(busy), 0);

    // Reset in the middle of an LW memory wait.
    add_idle(0, 1); add_instr(OP_LW, 3'd2, 7'h00, 4, 1); play_n(6);
    do_reset();
    add_idle(3, 0); play();
    chk("midreset_retired", 32'(retired), 0);

    // Randomized instruction stream.
    add_idle(1, 1);
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 9);
      f3 = 3'($urandom); f7 = 7'($urandom); waits = $urandom_range(0, 4);
      rn = 1'($urandom);
      case (sel)
        0, 1, 2: begin
          op = OP_R;
          f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end
        3, 4: begin
          op = OP_I;
          if (f3 == 3'd5) f7 = $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00;
          else if (f3 == 3'd1) f7 = 7'h00;
        end
        5: begin op = OP_LW; f3 = 3'd2; end
        6: begin op = OP_SW; f3 = 3'd2; end
        7: begin
          case ($urandom_range(0, 4))
            0: op = OP_R; 1: op = OP_I; 2: op = OP_LW; 3: op = OP_SW;
            default: op = 7'($urandom);
          endcase
        end
        8: begin
          op = $urandom_range(0, 1) == 1 ? OP_LW : OP_SW; f3 = 3'd2;
          waits = $urandom_range(int'(TIMEOUT) - 2, int'(TIMEOUT) + 1);
        end
        default: begin op = OP_R; f7 = $urandom_range(0, 1) == 1 ? 7'h20 : 7'($urandom); end
      endcase
      add_instr(op, f3, f7, waits, rn);
      if (m_fault) begin
        play(); do_reset(); add_idle($urandom_range(0, 1), 1);
      end else if (!rn) begin
        add_idle($urandom_range(0, 2), 1);
      end
      play();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
